mpy_seq_ctrl: RTL and testbench

MPY_SEQ_CTRL -- requirements
Module: mpy_seq_ctrl

---
 rtl/mpy_pkg.sv | 12 +
 rtl/mpy_shift_add_step.sv | 24 ++
 rtl/mpy_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_mpy_seq_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mpy_pkg.sv
// Shared types and constants for the sequential multiplier controller.
package mpy_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam logic [4:0] FS_MULT = 5'h2;

endpackage

// File: rtl/mpy_shift_add_step.sv
// One radix-2 shift-add iteration: conditionally add the multiplicand into the upper
// accumulator, then shift {carry, acc_hi, mplier} right by one.
module mpy_shift_add_step
  import mpy_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] mplier,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH-1:0] acc_hi_next,
  output logic [WIDTH-1:0] mplier_next
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum         = {1'b0, acc_hi} + (mplier[0] ? {1'b0, mcand} : '0);
    acc_hi_next = sum[WIDTH:1];
    // Product low bits retire into the vacated top of the multiplier register.
    mplier_next = {sum[0], mplier[WIDTH-1:1]};
  end

endmodule

// File: rtl/mpy_seq_ctrl.sv
// Sequential WIDTH-cycle shift-add multiplier controller.
// Define MPY_SIGNED_EN to enable two's-complement operands selected by sgn.
module mpy_seq_ctrl
  import mpy_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       FS,
  input  logic             sgn,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] T,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y_hi,
  output logic [WIDTH-1:0] Y_lo,
  output logic             N,
  output logic             Z
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH);

  state_e state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_step, mplier_step;
  logic [WIDTH-1:0]   cap_s, cap_t;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   y_hi_q, y_lo_q;
  logic               n_q, z_q;
  logic               start_ok;
  logic               load_y;

  assign start_ok = start && (FS == FS_MULT);

`ifdef MPY_SIGNED_EN
  logic neg_q;

  // Iterate on magnitudes; the sign is reapplied once on the final product.
  assign cap_s = (sgn && S[WIDTH-1]) ? -S : S;
  assign cap_t = (sgn && T[WIDTH-1]) ? -T : T;
  assign prod  = neg_q ? -{acc_q, mplier_q} : {acc_q, mplier_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_q <= 1'b0;
    end else if (state_q == StIdle && start_ok) begin
      neg_q <= sgn && (S[WIDTH-1] ^ T[WIDTH-1]);
    end
  end
`else
  logic unused_sgn;

  assign unused_sgn = sgn;
  assign cap_s      = S;
  assign cap_t      = T;
  assign prod       = {acc_q, mplier_q};
`endif

  mpy_shift_add_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc_hi     (acc_q),
    .mplier     (mplier_q),
    .mcand      (mcand_q),
    .acc_hi_next(acc_step),
    .mplier_next(mplier_step)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    load_y   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d  = StRun;
          cnt_d    = '0;
          mcand_d  = cap_s;
          acc_d    = '0;
          mplier_d = cap_t;
        end
      end
      StRun: begin
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          load_y  = 1'b1;
        end else begin
          cnt_d    = cnt_q + 1'b1;
          acc_d    = acc_step;
          mplier_d = mplier_step;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_hi_q <= '0;
      y_lo_q <= '0;
      n_q    <= 1'b0;
      z_q    <= 1'b1;
    end else if (load_y) begin
      y_hi_q <= prod[2*WIDTH-1:WIDTH];
      y_lo_q <= prod[WIDTH-1:0];
      n_q    <= prod[2*WIDTH-1];
      z_q    <= (prod == '0);
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign Y_hi = y_hi_q;
  assign Y_lo = y_lo_q;
  assign N    = n_q;
  assign Z    = z_q;

endmodule

// File: tb/tb_mpy_seq_ctrl.sv
// Self-checking bench for mpy_seq_ctrl: directed literal cases plus randomized traffic
// checked every cycle against a countdown/arithmetic reference model.
module tb_mpy_seq_ctrl;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [4:0]    FS = 5'h0;
  logic          sgn = 1'b0;
  logic [W-1:0]  S = '0;
  logic [W-1:0]  T = '0;
  logic          busy, done, N, Z;
  logic [W-1:0]  Y_hi, Y_lo;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  mpy_seq_ctrl #(
    .WIDTH(W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .FS   (FS),
    .sgn  (sgn),
    .S    (S),
    .T    (T),
    .busy (busy),
    .done (done),
    .Y_hi (Y_hi),
    .Y_lo (Y_lo),
    .N    (N),
    .Z    (Z)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic sg);
    logic sm;
`ifdef MPY_SIGNED_EN
    sm = sg;
`else
    sm = 1'b0 & sg;
`endif
    if (sm) return $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  // Reference: an accepted request becomes visible W+1 edges later for one cycle.
  int             m_left = 0;
  logic           m_done = 1'b0;
  logic [2*W-1:0] m_prod = '0;
  logic [2*W-1:0] m_pend = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_prod <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_prod <= m_pend;
        end
      end else if (!m_done && start && FS == 5'h2) begin
        m_left <= W + 1;
        m_pend <= ref_prod(S, T, sgn);
      end
    end
  end

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #2;
    if (chk_en) begin
      check("busy", 128'(busy), 128'((m_left != 0) || m_done));
      check("done", 128'(done), 128'(m_done));
      check("Y", {Y_hi, Y_lo}, m_prod);
      check("N", 128'(N), 128'(m_prod[2*W-1]));
      check("Z", 128'(Z), 128'(m_prod == '0));
    end
  end

  task automatic run_op(input logic [W-1:0] s, input logic [W-1:0] t, input logic sg,
                        input bit poke, output int cyc, output logic [2*W-1:0] y,
                        output logic nf, output logic zf);
    int dones;
    S = s; T = t; sgn = sg; FS = 5'h2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    S = $urandom; T = $urandom; sgn = ~sg;
    cyc = 0;
    dones = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      start = (poke && cyc == 5);
      if (done) break;
    end
    check("done_seen", 128'(done), 128'(1));
    y = {Y_hi, Y_lo};
    nf = N;
    zf = Z;
    @(negedge clk);
    check("done_single", 128'(done), 128'(0));
    check("idle_after", 128'(busy), 128'(0));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 5)
      0: return '0;
      1: return '1;
      2: return {1'b1, {(W-1){1'b0}}};
      3: return W'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cyc;
    logic [2*W-1:0] y;
    logic nf, zf;

    #2 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_Y", {Y_hi, Y_lo}, '0);
    check("rst_Z", 128'(Z), 128'(1));
    reset = 1'b0;

    run_op(32'd3, 32'd5, 1'b0, 1'b0, cyc, y, nf, zf);
    check("lat_3x5", 128'(cyc), 128'(33));
    check("y_3x5", y, 64'd15);
    check("nz_3x5", 128'({nf, zf}), 128'(0));

    // Non-multiply function select must leave everything untouched.
    S = 32'd9; T = 32'd9; FS = 5'h3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("fs3_busy", 128'(busy), 128'(0));
      check("fs3_y", {Y_hi, Y_lo}, 64'd15);
      @(negedge clk);
    end

    run_op('1, '1, 1'b0, 1'b0, cyc, y, nf, zf);
    check("y_max", y, 64'hFFFFFFFE_00000001);
    check("n_max", 128'(nf), 128'(1));

    run_op(32'hFFFFFFFE, 32'd3, 1'b1, 1'b0, cyc, y, nf, zf);
`ifdef MPY_SIGNED_EN
    check("y_m2x3", y, 64'hFFFFFFFF_FFFFFFFA);
    check("n_m2x3", 128'(nf), 128'(1));
    run_op(32'h80000000, 32'h80000000, 1'b1, 1'b0, cyc, y, nf, zf);
    check("y_minsq", y, 64'h40000000_00000000);
`else
    check("y_m2x3", y, 64'h00000002_FFFFFFFA);
    check("n_m2x3", 128'(nf), 128'(0));
`endif

    run_op(32'd0, 32'h12345678, 1'b0, 1'b0, cyc, y, nf, zf);
    check("lat_zero", 128'(cyc), 128'(33));
    check("y_zero", y, '0);
    check("z_zero", 128'(zf), 128'(1));

    run_op(32'd11, 32'd13, 1'b0, 1'b1, cyc, y, nf, zf);
    check("lat_poke", 128'(cyc), 128'(33));
    check("y_poke", y, 64'd143);

    // Abort mid-run with reset, then restart on the first edge after release.
    S = 32'hFFFF; T = 32'hFFFF; FS = 5'h2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_done", 128'(done), 128'(0));
    check("abort_Y", {Y_hi, Y_lo}, '0);
    check("abort_Z", 128'(Z), 128'(1));
    @(negedge clk);
    reset = 1'b0;
    run_op(32'd7, 32'd6, 1'b0, 1'b0, cyc, y, nf, zf);
    check("lat_7x6", 128'(cyc), 128'(33));
    check("y_7x6", y, 64'd42);

    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      start = ($urandom % 6 == 0);
      FS = ($urandom % 4 == 0) ? 5'($urandom) : 5'h2;
      S = pick();
      T = pick();
      sgn = 1'($urandom);
      reset = ($urandom % 700 == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
